// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters. Fetch presents a PC and receives a registered taken/target
// prediction one cycle later. Execute reports resolved branches; the branch
// target pc + 4 + (imm << OFFSET_SHIFT) is computed here and used to train
// the indexed entry.
//
// Optional feature macro: BTB_FWD_EN
//   defined   : a lookup in the same cycle as an update to the same index
//               sees the post-update entry; a same-cycle flush forces a miss.
//   undefined : a same-cycle lookup sees pre-update state.
//
// Ports
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   lookup_valid_i  in   fetch lookup request
//   lookup_pc_i     in   fetch PC
//   pred_valid_o    out  prediction valid (registered)
//   pred_taken_o    out  predicted taken
//   pred_target_o   out  predicted next PC
//   update_valid_i  in   resolved-branch report
//   update_pc_i     in   PC of the resolved branch
//   update_imm_i    in   sign-extended branch immediate
//   update_taken_i  in   actual outcome
//   flush_i         in   invalidate all entries
// ---------------------------------------------------------------------------
module branch_target_predictor #(
    parameter int ADDR_W       = 32,
    parameter int ENTRIES      = 16,
    parameter int OFFSET_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              update_valid_i,
    input  logic [ADDR_W-1:0] update_pc_i,
    input  logic [ADDR_W-1:0] update_imm_i,
    input  logic              update_taken_i,
    input  logic              flush_i
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic              pred_valid_q;
    logic              pred_taken_q;
    logic [ADDR_W-1:0] pred_target_q;

    // Instruction alignment bits never take part in index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

    // -----------------------------------------------------------------------
    // Update path
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_we;
    logic [ADDR_W-1:0] upd_target;
    logic [1:0]        upd_ctr_d;

    assign upd_idx    = update_pc_i[IDX_W+1:2];
    assign upd_tag    = update_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_target = update_pc_i + ADDR_W'(4) + (update_imm_i << OFFSET_SHIFT);

    // A not-taken miss leaves the table untouched; everything else writes
    // the full entry (on a hit valid/tag are rewritten with equal values).
    assign upd_we = update_valid_i && (upd_hit || update_taken_i);

    always_comb begin
        upd_ctr_d = 2'b10;
        if (upd_hit) begin
            if (update_taken_i)
                upd_ctr_d = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
            else
                upd_ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++)
                valid_q[i] <= 1'b0;
        end else if (upd_we) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= upd_ctr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Lookup path
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              ent_valid;
    logic [TAG_W-1:0]  ent_tag;
    logic [ADDR_W-1:0] ent_target;
    logic [1:0]        ent_ctr;
    logic              pred_taken_d;
    logic [ADDR_W-1:0] pred_target_d;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];

    always_comb begin
        ent_valid  = valid_q[lk_idx];
        ent_tag    = tag_q[lk_idx];
        ent_target = target_q[lk_idx];
        ent_ctr    = ctr_q[lk_idx];
`ifdef BTB_FWD_EN
        // Present the entry as it will look after this edge.
        if (flush_i) begin
            ent_valid = 1'b0;
        end else if (upd_we && (upd_idx == lk_idx)) begin
            ent_valid  = 1'b1;
            ent_tag    = upd_tag;
            ent_target = upd_target;
            ent_ctr    = upd_ctr_d;
        end
`endif
    end

    assign pred_taken_d  = ent_valid && (ent_tag == lk_tag) && ent_ctr[1];
    assign pred_target_d = pred_taken_d ? ent_target : lookup_pc_i + ADDR_W'(4);

    // pred_target holds across idle cycles; pred_taken is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q <= lookup_valid_i;
            if (lookup_valid_i) begin
                pred_taken_q  <= pred_taken_d;
                pred_target_q <= pred_target_d;
            end else begin
                pred_taken_q <= 1'b0;
            end
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Directed vectors against branch_target_predictor with default parameters
// (ENTRIES=16, index = pc[5:2]). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_branch_target_predictor;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_imm;
    logic        update_taken;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

    branch_target_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lookup_valid_i (lookup_valid),
        .lookup_pc_i    (lookup_pc),
        .pred_valid_o   (pred_valid),
        .pred_taken_o   (pred_taken),
        .pred_target_o  (pred_target),
        .update_valid_i (update_valid),
        .update_pc_i    (update_pc),
        .update_imm_i   (update_imm),
        .update_taken_i (update_taken),
        .flush_i        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] imm, input logic tkn);
        update_valid = 1'b1;
        update_pc    = pc;
        update_imm   = imm;
        update_taken = tkn;
        tick();
        update_valid = 1'b0;
    endtask

    task automatic chk_pred(input string tag, input logic exp_t, input logic [31:0] exp_tgt);
        chk({tag, ".valid"},  {31'd0, pred_valid}, 32'd1);
        chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, exp_t});
        chk({tag, ".target"}, pred_target, exp_tgt);
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_tgt);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        tick();
        lookup_valid = 1'b0;
        chk_pred(tag, exp_t, exp_tgt);
    endtask

    initial begin
        rst_n        = 1'b0;
        lookup_valid = 1'b0;
        lookup_pc    = '0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_imm   = '0;
        update_taken = 1'b0;
        flush        = 1'b0;
        tick();
        tick();
        chk("rst.valid",  {31'd0, pred_valid}, 32'd0);
        chk("rst.taken",  {31'd0, pred_taken}, 32'd0);
        chk("rst.target", pred_target, 32'd0);
        rst_n = 1'b1;
        tick();

        // Cold lookup, then idle cycle: valid/taken drop, target holds.
        look("cold", 32'h100, 1'b0, 32'h104);
        tick();
        chk("idle.valid",  {31'd0, pred_valid}, 32'd0);
        chk("idle.taken",  {31'd0, pred_taken}, 32'd0);
        chk("idle.target", pred_target, 32'h104);

        // Allocate: 0x100 + 4 + (0x10 << 2) = 0x144, ctr=10.
        upd(32'h100, 32'h10, 1'b1);
        look("alloc", 32'h100, 1'b1, 32'h144);

        // ctr 10 -> 01 -> 00
        upd(32'h100, 32'h10, 1'b0);
        look("nt1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 32'h10, 1'b0);
        look("nt2", 32'h100, 1'b0, 32'h104);

        // ctr 00 -> 01 -> 10 -> 11 -> 11 (saturates)
        for (int i = 0; i < 4; i++) upd(32'h100, 32'h10, 1'b1);
        look("sat", 32'h100, 1'b1, 32'h144);
        // 11 -> 10 still taken; 10 -> 01 not taken.
        upd(32'h100, 32'h10, 1'b0);
        look("sat_dn1", 32'h100, 1'b1, 32'h144);
        upd(32'h100, 32'h10, 1'b0);
        look("sat_dn2", 32'h100, 1'b0, 32'h104);

        // Negative offset wrap: 0 + 4 + 0xFFFFFFFC = 0. Replaces 0x100 at index 0.
        upd(32'h0, 32'hFFFF_FFFF, 1'b1);
        look("neg_wrap", 32'h0, 1'b1, 32'h0);
        // Fall-through wrap and taken-target wrap at the top of the space.
        look("ft_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        upd(32'hFFFF_FFFC, 32'h0, 1'b1);
        look("tgt_wrap", 32'hFFFF_FFFC, 1'b1, 32'h0);

        // Alias at index 0: retrain 0x100, then 0x140 evicts it.
        upd(32'h100, 32'h10, 1'b1);
        look("retrain", 32'h100, 1'b1, 32'h144);
        look("evicted0", 32'h0, 1'b0, 32'h4);
        upd(32'h140, 32'h4, 1'b1);
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 32'h154);

        // Flush with same-cycle update to 0x200 and same-cycle lookup of 0x140.
        flush        = 1'b1;
        update_valid = 1'b1;
        update_pc    = 32'h200;
        update_imm   = 32'h0;
        update_taken = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h140;
        tick();
        flush        = 1'b0;
        update_valid = 1'b0;
        lookup_valid = 1'b0;
`ifdef BTB_FWD_EN
        chk_pred("flush_same", 1'b0, 32'h144);
`else
        chk_pred("flush_same", 1'b1, 32'h154);
`endif
        look("flush_140", 32'h140, 1'b0, 32'h144);
        look("flush_200", 32'h200, 1'b0, 32'h204);
        look("flush_top", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Same-cycle lookup and first taken update of 0x100.
        update_valid = 1'b1;
        update_pc    = 32'h100;
        update_imm   = 32'h10;
        update_taken = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        tick();
        update_valid = 1'b0;
        lookup_valid = 1'b0;
`ifdef BTB_FWD_EN
        chk_pred("fwd_same", 1'b1, 32'h144);
`else
        chk_pred("fwd_same", 1'b0, 32'h104);
`endif
        look("fwd_after", 32'h100, 1'b1, 32'h144);

        // Asynchronous reset mid-lookup clears outputs immediately and the table.
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid",  {31'd0, pred_valid}, 32'd0);
        chk("mrst.taken",  {31'd0, pred_taken}, 32'd0);
        chk("mrst.target", pred_target, 32'd0);
        lookup_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        look("mrst_miss", 32'h100, 1'b0, 32'h104);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
